spine_egress_arbiter: RTL
=========================

// Module: spine_egress_arbiter
// PURPOSE
//  Shares one router egress link (GPU-side or spine output) between NREQ single-flit-wide requesters
//  (GPU NI injection + spine ingress FIFOs). Round-robin arbitration with packet lock: a winner keeps
//  the link until it transfers a flit with req_last. Credit-based flow control toward the downstream
//  buffer. Registered output stage drives the link at 1-cycle latency.
// PARAMETERS
//  NREQ     5   number of requesters (index 0 = GPU NI, 1..4 = spine14..spine44)
//  DWIDTH   16  flit width; dest addr in bits [DWIDTH-1:DWIDTH-6]
//  CREDITS  4   downstream buffer depth = initial/maximum credit count
//  CW       3   credit counter width, must hold CREDITS
// PORTS
//  clk            in   1             clock, all logic rising-edge
//  reset          in   1             synchronous, active-high
//  req_valid      in   NREQ          requester i has a flit
//  req_data       in   NREQ*DWIDTH   flit of requester i at [i*DWIDTH +: DWIDTH]
//  req_last       in   NREQ          flit of requester i is the packet tail
//  req_ready      out  NREQ          flit of requester i is consumed this cycle (valid&ready)
//  out_data       out  DWIDTH        registered egress flit
//  out_valid      out  1             out_data valid; one flit per cycle
//  out_owner      out  NREQ          one-hot source of the flit on out_data; 0 when !out_valid
//  credit_return  in   1             downstream freed one slot
//  credit_count   out  CW            credits currently available
//  busy           out  1             FSM in LOCKED
//  credit_err     out  1             sticky: credit_return while credit_count==CREDITS
// BEHAVIOUR
//  Reset (sync): state=IDLE, rr_ptr=NREQ-1 (requester 0 wins first), owner=0, credit_count=CREDITS,
//   out_data=0, out_valid=0, out_owner=0, busy=0, credit_err=0. Reset mid-packet drops the lock; no flush.
//  can_send = (credit_count != 0).
//  IDLE: if can_send and any req_valid: pick first valid i scanning rr_ptr+1, rr_ptr+2, ... mod NREQ.
//   req_ready[i]=1 same cycle (combinational), all others 0. Transfer happens.
//   - req_last[i]=1 -> stay IDLE, rr_ptr<=i.
//   - req_last[i]=0 -> LOCKED, owner<=i.
//   No valid or !can_send -> all req_ready=0, stay IDLE, rr_ptr unchanged.
//  LOCKED: req_ready[owner]=can_send & req_valid[owner]; all others 0 regardless of their valid.
//   Transfer with req_last -> IDLE, rr_ptr<=owner. Owner bubbles (valid=0) hold the lock indefinitely.
//  req_ready never asserts without the corresponding req_valid; at most one req_ready high per cycle.
//  Output stage: on transfer from i, next cycle out_valid=1, out_data=req_data[i], out_owner=1<<i;
//   otherwise out_valid=0, out_owner=0, out_data holds previous value. Latency req->out = 1 cycle.
//  Credits: transfer -> -1; credit_return -> +1; both same cycle -> unchanged.
//   credit_return at CREDITS (without simultaneous transfer) -> count saturates, credit_err<=1 (sticky until reset).
//   Count never underflows: transfer impossible at 0 (req_ready gated).
//  busy = (state==LOCKED). Dest addr field not interpreted; routing decided upstream.
// TESTING
//  1. After reset, req_valid=5'b00011, both last=1, data0=16'hA001,data1=16'hB002 -> cycle1 out 16'hA001 owner 00001,
//     cycle2 out 16'hB002 owner 00010; credit_count 4->3->2.
//  2. Req 2 sends 3-flit packet (last on 3rd) while req 0,4 valid continuously -> three req2 flits back-to-back,
//     then 4 granted before 0 (rr from ptr=2); busy high exactly during flits 1-2.
//  3. No credit_return, 5 single-flit requests from req 0 -> 4 flits out, req_ready[0]=0 at credit_count=0;
//     one credit_return -> 5th flit out next cycle.
//  4. credit_return and transfer in same cycle at credit_count=2 -> count stays 2; credit_return at count=4
//     with no transfer -> count 4, credit_err=1 and stays 1.
//  5. LOCKED on req 3, owner drops valid for 3 cycles while others valid -> no output, no other ready; resumes on 3.
//  6. reset asserted mid-packet (LOCKED on 1) -> next cycle IDLE, credit_count=4, out_valid=0, req 0 wins first.

Source files
------------

// File: rtl/spine_egress_arbiter_if.sv
// Egress arbiter bus: requester-side handshake, registered egress link,
// credit return and status. The arbiter sits on the slave modport.
interface spine_egress_arbiter_if #(
    parameter int NREQ   = 5,
    parameter int DWIDTH = 16,
    parameter int CW     = 3
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DWIDTH-1:0] req_data;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        req_ready;
    logic [DWIDTH-1:0]      out_data;
    logic                   out_valid;
    logic [NREQ-1:0]        out_owner;
    logic                   credit_return;
    logic [CW-1:0]          credit_count;
    logic                   busy;
    logic                   credit_err;

    modport master (
        output req_valid, req_data, req_last, credit_return,
        input  req_ready, out_data, out_valid, out_owner, credit_count, busy, credit_err
    );

    modport slave (
        input  req_valid, req_data, req_last, credit_return,
        output req_ready, out_data, out_valid, out_owner, credit_count, busy, credit_err
    );
endinterface

// File: rtl/spine_egress_arbiter.sv
// Round-robin egress arbiter with packet lock, credit-based flow control
// toward the downstream buffer and a registered 1-cycle output stage.
module spine_egress_arbiter #(
    parameter int NREQ    = 5,
    parameter int DWIDTH  = 16,
    parameter int CREDITS = 4,
    parameter int CW      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    spine_egress_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]        state_q;
    logic [IW-1:0]     rr_ptr_q;
    logic [IW-1:0]     owner_q;
    logic [CW-1:0]     credit_q;
    logic              credit_err_q;
    logic [DWIDTH-1:0] out_data_q;
    logic              out_valid_q;
    logic [NREQ-1:0]   out_owner_q;

    logic              can_send;
    logic              grant_found;
    logic [IW-1:0]     grant_idx;
    logic [IW-1:0]     cand_idx;
    logic [IW-1:0]     sel_idx;
    logic              sel_ok;
    logic              xfer;
    logic              xfer_last;
    logic [NREQ-1:0]   ready_d;

    logic [DWIDTH-1:0] req_flit [NREQ];

    // Unpack the flat flit bus into one flit per requester.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign req_flit[gi] = bus.req_data[gi*DWIDTH +: DWIDTH];
        end
    endgenerate

    // Pick the winner: round-robin search in IDLE, the locked owner otherwise.
    always_comb begin
        can_send    = (credit_q != '0);
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_idx = IW'((int'(rr_ptr_q) + k) % NREQ);
            if (!grant_found && bus.req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
        sel_idx   = (state_q == ST_LOCKED) ? owner_q : grant_idx;
        sel_ok    = (state_q == ST_LOCKED) ? bus.req_valid[owner_q] : grant_found;
        xfer      = can_send && sel_ok;
        xfer_last = bus.req_last[sel_idx];
        ready_d   = '0;
        if (xfer) begin
            ready_d[sel_idx] = 1'b1;
        end
    end

    // Packet lock FSM and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= IW'(NREQ - 1);
            owner_q  <= '0;
        end else if (xfer) begin
            if (xfer_last) begin
                state_q  <= ST_IDLE;
                rr_ptr_q <= sel_idx;
            end else begin
                state_q <= ST_LOCKED;
                owner_q <= sel_idx;
            end
        end
    end

    // Credit counter: a transfer and a return in the same cycle cancel out;
    // a return with the counter already full is flagged and ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q     <= CW'(CREDITS);
            credit_err_q <= 1'b0;
        end else begin
            case ({xfer, bus.credit_return})
                2'b10: credit_q <= credit_q - CW'(1);
                2'b01: begin
                    if (credit_q == CW'(CREDITS)) begin
                        credit_err_q <= 1'b1;
                    end else begin
                        credit_q <= credit_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered egress stage; data holds its last value between flits.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_owner_q <= '0;
        end else begin
            out_valid_q <= xfer;
            out_owner_q <= xfer ? (NREQ'(1) << sel_idx) : '0;
            if (xfer) begin
                out_data_q <= req_flit[sel_idx];
            end
        end
    end

    assign bus.req_ready    = ready_d;
    assign bus.out_data     = out_data_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_owner    = out_owner_q;
    assign bus.credit_count = credit_q;
    assign bus.busy         = (state_q == ST_LOCKED);
    assign bus.credit_err   = credit_err_q;
endmodule
